// File: rtl/prf_gen.sv
// Pulse-repetition timing generator: produces the prf gate, the delayed tr window,
// the ct calibration window and one-cycle edge strobes for prf and tr.
module prf_gen #(
  parameter int CNT_W = 32,
  parameter int CT_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic [CNT_W-1:0] pulse_clock_num,
  input  logic [CNT_W-1:0] sweep_clock_num,
  input  logic [CNT_W-1:0] ys_clock_num,
  input  logic [CT_W-1:0]  ct_clock_num,
  output logic             tr,
  output logic [1:0]       tr_edge,
  output logic             prf,
  output logic [1:0]       prf_edge,
  output logic             ct
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d, s_q, s_d, y_q, y_d;
  logic [CT_W-1:0]  c_q, c_d;
  logic [CNT_W-1:0] pend_p_q, pend_p_d, pend_s_q, pend_s_d, pend_y_q, pend_y_d;
  logic [CT_W-1:0]  pend_c_q, pend_c_d;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CT_W-1:0]  ctc_q, ctc_d;
  logic             prf_q, prf_d, tr_q, tr_d, ct_q, ct_d;
  logic [1:0]       prf_edge_q, prf_edge_d, tr_edge_q, tr_edge_d;

  logic             run;
  logic [CNT_W-1:0] pe;
  logic [CNT_W:0]   y_plus_pe;

  assign run = (state_q == RUN);

  // Pulse width is clipped to S-1 so that prf always has a low cycle each period.
  always_comb begin
    pe = '0;
    if (s_q >= CNT_W'(2)) begin
      pe = (p_q < s_q - CNT_W'(1)) ? p_q : s_q - CNT_W'(1);
    end
    y_plus_pe = {1'b0, y_q} + {1'b0, pe};
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    s_d        = s_q;
    y_d        = y_q;
    c_d        = c_q;
    pend_p_d   = pend_p_q;
    pend_s_d   = pend_s_q;
    pend_y_d   = pend_y_q;
    pend_c_d   = pend_c_q;
    restart_d  = 1'b0;
    cnt_d      = cnt_q;
    ctc_d      = ctc_q;

    prf_d = run & (cnt_q < pe);
    tr_d  = run & (cnt_q >= y_q) & ({1'b0, cnt_q} < y_plus_pe) & (cnt_q < s_q);
    ct_d  = run & (ctc_q < c_q);
    prf_edge_d = {prf_q & ~prf_d, ~prf_q & prf_d};
    tr_edge_d  = {tr_q & ~tr_d, ~tr_q & tr_d};

    if (run) begin
      cnt_d = (cnt_q == s_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
      if (ctc_q < c_q) begin
        ctc_d = ctc_q + CT_W'(1);
      end
    end

    // Inputs are captured on update and applied one cycle later, which overrides any wrap.
    if (restart_q) begin
      p_d     = pend_p_q;
      s_d     = pend_s_q;
      y_d     = pend_y_q;
      c_d     = pend_c_q;
      cnt_d   = '0;
      ctc_d   = '0;
      state_d = (pend_s_q != '0) ? RUN : IDLE;
    end

    if (update) begin
      pend_p_d  = pulse_clock_num;
      pend_s_d  = sweep_clock_num;
      pend_y_d  = ys_clock_num;
      pend_c_d  = ct_clock_num;
      restart_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      s_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      pend_p_q   <= '0;
      pend_s_q   <= '0;
      pend_y_q   <= '0;
      pend_c_q   <= '0;
      restart_q  <= 1'b0;
      cnt_q      <= '0;
      ctc_q      <= '0;
      prf_q      <= 1'b0;
      tr_q       <= 1'b0;
      ct_q       <= 1'b0;
      prf_edge_q <= 2'b00;
      tr_edge_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      s_q        <= s_d;
      y_q        <= y_d;
      c_q        <= c_d;
      pend_p_q   <= pend_p_d;
      pend_s_q   <= pend_s_d;
      pend_y_q   <= pend_y_d;
      pend_c_q   <= pend_c_d;
      restart_q  <= restart_d;
      cnt_q      <= cnt_d;
      ctc_q      <= ctc_d;
      prf_q      <= prf_d;
      tr_q       <= tr_d;
      ct_q       <= ct_d;
      prf_edge_q <= prf_edge_d;
      tr_edge_q  <= tr_edge_d;
    end
  end

  assign prf      = prf_q;
  assign tr       = tr_q;
  assign ct       = ct_q;
  assign prf_edge = prf_edge_q;
  assign tr_edge  = tr_edge_q;

endmodule

// File: tb/tb_prf_gen.sv
// Self-checking bench for prf_gen: a time-since-restart model predicts every output
// each cycle, and window counts pin both the model and the DUT to hand-computed values.
module tb_prf_gen;
  localparam int CNT_W = 32;
  localparam int CT_W  = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             update = 1'b0;
  logic [CNT_W-1:0] pulse_clock_num = '0;
  logic [CNT_W-1:0] sweep_clock_num = '0;
  logic [CNT_W-1:0] ys_clock_num = '0;
  logic [CT_W-1:0]  ct_clock_num = '0;
  logic             tr, prf, ct;
  logic [1:0]       tr_edge, prf_edge;

  int errors = 0;
  int checks = 0;

  prf_gen #(.CNT_W(CNT_W), .CT_W(CT_W)) dut (
    .clk(clk), .rst(rst), .update(update),
    .pulse_clock_num(pulse_clock_num), .sweep_clock_num(sweep_clock_num),
    .ys_clock_num(ys_clock_num), .ct_clock_num(ct_clock_num),
    .tr(tr), .tr_edge(tr_edge), .prf(prf), .prf_edge(prf_edge), .ct(ct)
  );

  always #5 clk = ~clk;

  // Model state: the active configuration and the edge at which it restarted.
  longint t = 0;
  longint rstart = 0;
  bit     m_run = 0;
  longint cur_p = 0, cur_s = 0, cur_y = 0, cur_c = 0;
  bit     pend_v = 0;
  longint pend_p = 0, pend_s = 0, pend_y = 0, pend_c = 0;
  logic   exp_prf = 0, exp_tr = 0, exp_ct = 0;
  logic [1:0] exp_prf_edge = 0, exp_tr_edge = 0;

  always @(posedge clk) begin
    logic np, nt, nc;
    longint k, m, pe;
    t++;
    np = 0; nt = 0; nc = 0;
    if (!rst) begin
      m_run  = 0;
      pend_v = 0;
      exp_prf_edge = 2'b00;
      exp_tr_edge  = 2'b00;
    end else begin
      if (m_run) begin
        k  = t - rstart - 1;
        m  = k % cur_s;
        pe = (cur_s >= 2) ? ((cur_p < cur_s - 1) ? cur_p : cur_s - 1) : 0;
        np = (m < pe);
        nt = (m >= cur_y) && (m < cur_y + pe);
        nc = (k < cur_c);
      end
      if (pend_v) begin
        cur_p = pend_p; cur_s = pend_s; cur_y = pend_y; cur_c = pend_c;
        m_run  = (pend_s != 0);
        rstart = t;
        pend_v = 0;
      end
      if (update) begin
        pend_p = longint'(pulse_clock_num);
        pend_s = longint'(sweep_clock_num);
        pend_y = longint'(ys_clock_num);
        pend_c = longint'(ct_clock_num[62:0]);
        pend_v = 1;
      end
      exp_prf_edge = {exp_prf & ~np, ~exp_prf & np};
      exp_tr_edge  = {exp_tr & ~nt, ~exp_tr & nt};
    end
    exp_prf = np;
    exp_tr  = nt;
    exp_ct  = nc;
  end

  bit check_on = 0;
  bit counting = 0;
  int d_prf = 0, d_tr = 0, d_ct = 0;
  int m_prf = 0, m_tr = 0, m_ct = 0;

  task automatic checkOutput();
    checks++;
    if (prf !== exp_prf) begin errors++; $display("[TB] FAIL prf t=%0d got %b want %b", t, prf, exp_prf); end
    checks++;
    if (tr !== exp_tr) begin errors++; $display("[TB] FAIL tr t=%0d got %b want %b", t, tr, exp_tr); end
    checks++;
    if (ct !== exp_ct) begin errors++; $display("[TB] FAIL ct t=%0d got %b want %b", t, ct, exp_ct); end
    checks++;
    if (prf_edge !== exp_prf_edge) begin errors++; $display("[TB] FAIL prf_edge t=%0d got %b want %b", t, prf_edge, exp_prf_edge); end
    checks++;
    if (tr_edge !== exp_tr_edge) begin errors++; $display("[TB] FAIL tr_edge t=%0d got %b want %b", t, tr_edge, exp_tr_edge); end
  endtask

  always @(negedge clk) begin
    if (check_on) checkOutput();
    if (counting) begin
      d_prf += int'(prf === 1'b1); d_tr += int'(tr === 1'b1); d_ct += int'(ct === 1'b1);
      m_prf += int'(exp_prf); m_tr += int'(exp_tr); m_ct += int'(exp_ct);
    end
  end

  task automatic checkLit(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic checkCounts(input string name, input int ep, input int et, input int ec);
    checkLit({name, "_prf_dut"}, d_prf, ep);
    checkLit({name, "_tr_dut"},  d_tr,  et);
    checkLit({name, "_ct_dut"},  d_ct,  ec);
    checkLit({name, "_prf_mod"}, m_prf, ep);
    checkLit({name, "_tr_mod"},  m_tr,  et);
    checkLit({name, "_ct_mod"},  m_ct,  ec);
  endtask

  task automatic clearCounts();
    d_prf = 0; d_tr = 0; d_ct = 0; m_prf = 0; m_tr = 0; m_ct = 0;
  endtask

  // Call just after a clock edge; returns #1 after the edge that samples update.
  task automatic applyStimulus(input longint p, input longint s, input longint y, input longint c);
    pulse_clock_num = CNT_W'(p);
    sweep_clock_num = CNT_W'(s);
    ys_clock_num    = CNT_W'(y);
    ct_clock_num    = CT_W'(c);
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
    pulse_clock_num = $urandom;
    sweep_clock_num = $urandom;
    ys_clock_num    = $urandom;
    ct_clock_num    = {$urandom, $urandom};
  endtask

  // Counts w output cycles starting with period cycle 0 of the new configuration.
  task automatic countWindow(input int w);
    @(posedge clk);
    @(posedge clk);
    #1;
    clearCounts();
    counting = 1;
    repeat (w) @(negedge clk);
    #1;
    counting = 0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_on = 1;
    rst = 1'b1;
    clearCounts();
    counting = 1;
    repeat (1000) @(negedge clk);
    #1;
    counting = 0;
    checkCounts("idle", 0, 0, 0);

    applyStimulus(10, 100, 20, 0);
    countWindow(200);
    checkCounts("basic", 20, 20, 0);

    applyStimulus(10, 25, 20, 0);
    countWindow(100);
    checkCounts("clip_tr", 40, 20, 0);

    applyStimulus(50, 25, 0, 0);
    countWindow(100);
    checkCounts("clip_prf", 96, 96, 0);

    applyStimulus(10, 100, 200, 0);
    countWindow(200);
    checkCounts("y_ge_s", 20, 0, 0);

    applyStimulus(10, 0, 5, 100);
    countWindow(200);
    checkCounts("disable", 0, 0, 0);

    applyStimulus(10, 100, 5, 350);
    @(posedge clk);
    #1;
    checkLit("lat_prf_n1", longint'(prf), 0);
    clearCounts();
    counting = 1;
    @(posedge clk);
    #1;
    checkLit("lat_prf_n2", longint'(prf), 1);
    checkLit("lat_ct_n2", longint'(ct), 1);
    checkLit("lat_edge_n2", longint'(prf_edge), 1);
    repeat (197) @(posedge clk);
    #1;
    applyStimulus(10, 100, 5, 350);
    repeat (400) @(posedge clk);
    #1;
    counting = 0;
    checkCounts("calib", 60, 60, 550);

    applyStimulus(10, 100, 5, 350);
    repeat (5) @(posedge clk);
    #1;
    checkLit("pre_rst_prf", longint'(prf), 1);
    checkLit("pre_rst_ct", longint'(ct), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkLit("rst_prf", longint'(prf), 0);
    checkLit("rst_ct", longint'(ct), 0);
    checkLit("rst_prf_edge", longint'(prf_edge), 0);
    checkLit("rst_tr_edge", longint'(tr_edge), 0);
    countWindow(300);
    checkCounts("post_rst", 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0)
        applyStimulus($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 12));
      else
        applyStimulus($urandom_range(0, 40), $urandom_range(0, 60), $urandom_range(0, 70), $urandom_range(0, 200));
      repeat ($urandom_range(0, 150)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prf_gen.md
Name: prf_gen

Overview:
- Timing generator directly downstream of the SPI command deframer path and upstream of the command-update / AD9914 control stages.
- Produces three signals:
  - the pulse-repetition gate `prf`
  - the delayed transmit/trigger window `tr`
  - the calibration window `ct`
- Also produces one-cycle edge strobes for `prf` and `tr`, consumed by the command-update logic to time DDS loads and sweeps.
- All timing is expressed in `clk` cycles, already scaled upstream from command units.

Parameters:
- CNT_W, 32, width of pulse/sweep/delay counts and the period counter.
- CT_W, 64, width of the calibration count and the calibration counter.

Ports:
- clk  input  1  system clock; the single clock of the block.
- rst  input  1  reset; synchronous, active-low.
- update  input  1  one-cycle strobe; latch new counts and restart timing.
- pulse_clock_num  input  CNT_W  pulse width in clk cycles.
- sweep_clock_num  input  CNT_W  repetition period in clk cycles.
- ys_clock_num  input  CNT_W  trigger delay from period start, in clk cycles.
- ct_clock_num  input  CT_W  calibration window length in clk cycles.
- tr  output  1  trigger/transmit window.
- tr_edge  output  2  bit0 = tr rising strobe, bit1 = tr falling strobe.
- prf  output  1  pulse-repetition gate.
- prf_edge  output  2  bit0 = prf rising strobe, bit1 = prf falling strobe.
- ct  output  1  calibration window active.

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - All outputs go to 0.
  - Shadow registers P, S, Y, C go to 0.
  - Counters cnt and ctc go to 0.
  - run goes to 0.
  - Reset has priority over update.
- Reset mid-operation aborts any window immediately. No edge strobes are generated by reset.
- State: IDLE (run=0) / RUN (run=1).
  - Leave IDLE only via update.
  - update in either state: P<=pulse_clock_num, S<=sweep_clock_num, Y<=ys_clock_num, C<=ct_clock_num, cnt<=0, ctc<=0, run<=(sweep_clock_num!=0).
  - update with sweep_clock_num=0 → IDLE; outputs fall to 0 next cycle, with falling strobes for any level that was 1.
- Inputs are sampled only on update. Input changes at other times have no effect.
- Period counter (RUN):
  - cnt increments by 1 per cycle.
  - When cnt=S-1, next value is 0 (wrap).
  - A cycle with update overrides the wrap.
- Effective pulse width: Pe = min(P, S-1) when S≥2, and Pe = 0 when S=1. This guarantees a falling prf edge every period.
- Level decode (registered; outputs reflect cnt one cycle later):
  - prf <= run & (cnt < Pe).
  - tr <= run & (cnt ≥ Y) & (cnt < Y+Pe) & (cnt < S).
  - The tr window is clipped at the period end and is not carried into the next period.
  - Y ≥ S → tr never asserts.
  - Compute Y+Pe at CNT_W+1 bits; no wrap.
- Latency: update sampled at edge N → cnt=0 after edge N+1 → prf=1 after edge N+2 (if Pe>0).
- Edge strobes are registered on the same edge as the level change, from old vs new level:
  - x_edge <= {x & ~x_next, ~x & x_next}
  - Each strobe lasts exactly one cycle. 2'b11 never occurs.
  - A level held constant across an update restart produces no strobe.
- Calibration:
  - ctc increments while run=1 and ctc<C, then saturates at C.
  - ct <= run & (ctc < C). ct is 1 for exactly C cycles, starting the same cycle prf first rises.
  - C=0 → ct stays 0.
  - update during calibration restarts the window with the new C.
- Simultaneous events: update in the same cycle as a wrap → the update restart wins; no extra period is counted.

Test Plan:
- Reset then idle: rst=0 for 5 cycles, then rst=1 with no update → all outputs and strobes stay 0 for 1000 cycles.
- Basic timing: update with P=10, S=100, Y=20, C=0 →
  - prf high 10 cycles every 100, first rise 2 cycles after update.
  - tr high for cycles 20..29 of each period.
  - prf_edge=01/10 and tr_edge=01/10 single-cycle pulses at those boundaries.
  - ct stays 0.
- Clipping: P=10, S=25, Y=20 → tr high only for period cycles 20..24 each period, then falls. P=50, S=25 → prf high 24 cycles, low 1 cycle, per period.
- Calibration: update with S=100, P=10, C=350 → ct high exactly 350 cycles, coincident with the first prf rise, then 0 forever. A second update at cycle 200 → ct restarts for another 350 cycles.
- Disable / degenerate:
  - update with S=0 while running → prf, tr, ct fall next cycle with falling strobes, and remain 0.
  - Y=200 with S=100 → tr never asserts.
- Reset mid-window: assert rst=0 while prf=1 and ct=1 → all outputs 0 next cycle, no strobes. After rst=1, nothing runs until a new update.
